// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register file write side: widths, entry layout,
// and the helper that widens a register index onto the 16-bit write code.
package reg_writeback_queue_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int RF_CODE_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [RF_CODE_W-1:0] rf_code(input logic [ADDR_W-1:0] addr);
    return {{(RF_CODE_W-ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup: walks the occupied entries from youngest (tail-1)
// back to oldest (head) and reports the first address match.
module wb_fwd_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      tail,
  input  logic [CNT_W-1:0]      count,
  input  logic [ADDR_W-1:0]     lookup_addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      // Only the first hit counts, so the youngest pending write wins.
      if (!hit && (CNT_W'(i) < count) && (entries[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Register file write side: two producers (ALU, memory load) feed an in-order
// queue that drains one entry per cycle, with two forwarding lookups for reads.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 rf_stall,
  output logic                 w_flag,
  output logic [RF_CODE_W-1:0] write_code,
  output logic [DATA_W-1:0]    w_data,
  input  logic [ADDR_W-1:0]    fwd_addr1,
  output logic                 fwd_hit1,
  output logic [DATA_W-1:0]    fwd_data1,
  input  logic [ADDR_W-1:0]    fwd_addr2,
  output logic                 fwd_hit2,
  output logic [DATA_W-1:0]    fwd_data2,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head_entry;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      mem_slot;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_vis;
  logic [CNT_W-1:0]      free;
  logic                  drain;
  logic                  alu_acc;
  logic                  mem_acc;

  // While reset is asserted the queue looks empty, even before the first edge.
  assign count_vis = rst_n ? count : '0;

  assign drain = (count_vis != '0) && !rf_stall;
  assign free  = CNT_W'(DEPTH) - count_vis + CNT_W'(drain);

  // With a single free slot the load wins; ALU only gets it if mem is idle.
  assign mem_ready = rst_n && (free != '0);
  assign alu_ready = rst_n && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid));

  assign alu_acc  = alu_valid && alu_ready;
  assign mem_acc  = mem_valid && mem_ready;
  assign mem_slot = tail + PTR_W'(alu_acc);

  assign head_entry = entries[head];
  assign w_flag     = drain;
  assign write_code = drain ? rf_code(head_entry.addr) : '0;
  assign w_data     = drain ? head_entry.data : '0;

  assign empty = (count_vis == '0);
  assign full  = (count_vis == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (alu_acc) begin
      entries[tail] <= '{addr: alu_addr, data: alu_data};
    end
    if (mem_acc) begin
      entries[mem_slot] <= '{addr: mem_addr, data: mem_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      tail  <= tail + PTR_W'(alu_acc) + PTR_W'(mem_acc);
      count <= count + CNT_W'(alu_acc) + CNT_W'(mem_acc) - CNT_W'(drain);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries     (entries),
    .tail        (tail),
    .count       (count_vis),
    .lookup_addr (fwd_addr1),
    .hit         (fwd_hit1),
    .data        (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries     (entries),
    .tail        (tail),
    .count       (count_vis),
    .lookup_addr (fwd_addr2),
    .hit         (fwd_hit2),
    .data        (fwd_data2)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a per-cycle vector table followed by
// hand-written stall-toggle and mid-operation reset sequences.
module tb_reg_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        rf_stall;
  logic        w_flag;
  logic [15:0] write_code;
  logic [15:0] w_data;
  logic [3:0]  fwd_addr1;
  logic        fwd_hit1;
  logic [15:0] fwd_data1;
  logic [3:0]  fwd_addr2;
  logic        fwd_hit2;
  logic [15:0] fwd_data2;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rf_stall   (rf_stall),
    .w_flag     (w_flag),
    .write_code (write_code),
    .w_data     (w_data),
    .fwd_addr1  (fwd_addr1),
    .fwd_hit1   (fwd_hit1),
    .fwd_data1  (fwd_data1),
    .fwd_addr2  (fwd_addr2),
    .fwd_hit2   (fwd_hit2),
    .fwd_data2  (fwd_data2),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [15:0] md;
    logic        stall;
    logic [3:0]  f1;
    logic [3:0]  f2;
    logic        e_ar;
    logic        e_mr;
    logic        e_wf;
    logic [15:0] e_wc;
    logic [15:0] e_wd;
    logic        e_h1;
    logic [15:0] e_d1;
    logic        e_h2;
    logic [15:0] e_d2;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vecs[17];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = 4'h0; alu_data = 16'h0;
    mem_valid = 1'b0; mem_addr = 4'h0; mem_data = 16'h0;
    rf_stall  = 1'b0; fwd_addr1 = 4'h0; fwd_addr2 = 4'h0;
  endtask

  logic [15:0] exp_wc[3];
  logic [15:0] exp_wd[3];

  initial begin
    // Row = one cycle; expectations are the combinational outputs before the edge.
    //          rst   av    aa    ad        mv    ma    md        stall f1    f2      ar    mr    wf    wc        wd        h1    d1        h2    d2        empty full
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 16'h0101, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 4'h0,   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 16'h0101, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 4'h0,   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h1, 4'h0,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'h3, 16'h00A5, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h3, 4'h0,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h3, 4'h4,   1'b1, 1'b1, 1'b1, 16'h0003, 16'h00A5, 1'b1, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h3, 4'h0,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'h5, 16'h1111, 1'b1, 4'h5, 16'h2222, 1'b1, 4'h5, 4'h5,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 4'h6,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h5, 4'h5,   1'b1, 1'b1, 1'b1, 16'h0005, 16'h1111, 1'b1, 16'h2222, 1'b1, 16'h2222, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h5, 4'h0,   1'b1, 1'b1, 1'b1, 16'h0005, 16'h2222, 1'b1, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h5, 4'h0,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'h1, 16'h0A01, 1'b1, 4'h2, 16'h0B02, 1'b1, 4'h1, 4'h2,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'h7, 16'h0A07, 1'b1, 4'h2, 16'h0B22, 1'b1, 4'h2, 4'h7,   1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0B02, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'h9, 16'h0A09, 1'b1, 4'h9, 16'h0B09, 1'b1, 4'h2, 4'h1,   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0B22, 1'b1, 16'h0A01, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 4'h9, 16'h0A09, 1'b1, 4'h9, 16'h0B09, 1'b0, 4'h9, 4'h7,   1'b0, 1'b1, 1'b1, 16'h0001, 16'h0A01, 1'b0, 16'h0000, 1'b1, 16'h0A07, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 4'h1,   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0B09, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h2, 4'h9,   1'b1, 1'b1, 1'b1, 16'h0002, 16'h0B02, 1'b1, 16'h0B22, 1'b1, 16'h0B09, 1'b0, 1'b1};

    rst_n = 1'b0;
    idle_inputs();

    for (int i = 0; i < 17; i++) begin
      rst_n     = vecs[i].rst_n;
      alu_valid = vecs[i].av;
      alu_addr  = vecs[i].aa;
      alu_data  = vecs[i].ad;
      mem_valid = vecs[i].mv;
      mem_addr  = vecs[i].ma;
      mem_data  = vecs[i].md;
      rf_stall  = vecs[i].stall;
      fwd_addr1 = vecs[i].f1;
      fwd_addr2 = vecs[i].f2;
      #1;
      check1 ($sformatf("v%0d alu_ready", i),  alu_ready,  vecs[i].e_ar);
      check1 ($sformatf("v%0d mem_ready", i),  mem_ready,  vecs[i].e_mr);
      check1 ($sformatf("v%0d w_flag", i),     w_flag,     vecs[i].e_wf);
      check16($sformatf("v%0d write_code", i), write_code, vecs[i].e_wc);
      check16($sformatf("v%0d w_data", i),     w_data,     vecs[i].e_wd);
      check1 ($sformatf("v%0d fwd_hit1", i),   fwd_hit1,   vecs[i].e_h1);
      check16($sformatf("v%0d fwd_data1", i),  fwd_data1,  vecs[i].e_d1);
      check1 ($sformatf("v%0d fwd_hit2", i),   fwd_hit2,   vecs[i].e_h2);
      check16($sformatf("v%0d fwd_data2", i),  fwd_data2,  vecs[i].e_d2);
      check1 ($sformatf("v%0d empty", i),      empty,      vecs[i].e_empty);
      check1 ($sformatf("v%0d full", i),       full,       vecs[i].e_full);
      next_cycle();
    end

    // Three entries remain (7:0A07, 2:0B22, 9:0B09); drain them under a toggling stall.
    exp_wc = '{16'h0007, 16'h0002, 16'h0009};
    exp_wd = '{16'h0A07, 16'h0B22, 16'h0B09};
    idle_inputs();
    begin
      int k;
      k = 0;
      for (int i = 0; i < 6; i++) begin
        rf_stall = ((i % 2) == 0);
        #1;
        check1($sformatf("stall%0d w_flag", i), w_flag, !rf_stall);
        if (!rf_stall) begin
          check16($sformatf("stall%0d write_code", i), write_code, exp_wc[k]);
          check16($sformatf("stall%0d w_data", i), w_data, exp_wd[k]);
          k++;
        end else begin
          check16($sformatf("stall%0d w_data idle", i), w_data, 16'h0000);
        end
        next_cycle();
      end
    end
    rf_stall = 1'b0;
    #1;
    check1("stall_end w_flag", w_flag, 1'b0);
    check1("stall_end empty", empty, 1'b1);
    next_cycle();

    // Queue three entries under stall, then reset while a drain would occur.
    rf_stall  = 1'b1;
    alu_valid = 1'b1; alu_addr = 4'h4; alu_data = 16'hC004;
    mem_valid = 1'b1; mem_addr = 4'h6; mem_data = 16'hC006;
    next_cycle();
    mem_valid = 1'b0;
    alu_addr  = 4'h8; alu_data = 16'hC008;
    next_cycle();
    alu_valid = 1'b0;
    fwd_addr1 = 4'h6;
    #1;
    check1 ("pre_rst fwd_hit1", fwd_hit1, 1'b1);
    check16("pre_rst fwd_data1", fwd_data1, 16'hC006);
    check1 ("pre_rst empty", empty, 1'b0);
    check1 ("pre_rst full", full, 1'b0);

    rst_n     = 1'b0;
    rf_stall  = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'h4; alu_data = 16'hDEAD;
    fwd_addr1 = 4'h4;
    #1;
    check1("in_rst w_flag", w_flag, 1'b0);
    check1("in_rst empty", empty, 1'b1);
    check1("in_rst alu_ready", alu_ready, 1'b0);
    check1("in_rst mem_ready", mem_ready, 1'b0);
    check1("in_rst fwd_hit1", fwd_hit1, 1'b0);
    next_cycle();

    rst_n     = 1'b1;
    alu_valid = 1'b0;
    #1;
    check1("post_rst empty", empty, 1'b1);
    check1("post_rst w_flag", w_flag, 1'b0);
    check1("post_rst alu_ready", alu_ready, 1'b1);
    check1("post_rst mem_ready", mem_ready, 1'b1);
    begin
      logic [3:0] old_addrs[3];
      old_addrs = '{4'h4, 4'h6, 4'h8};
      for (int i = 0; i < 3; i++) begin
        fwd_addr1 = old_addrs[i];
        #1;
        check1($sformatf("post_rst fwd_hit1 addr%0d", old_addrs[i]), fwd_hit1, 1'b0);
      end
    end
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
